// File: rtl/mc_datapath_hs_if.sv
// Memory-port handshake bundle between the multicycle datapath (master) and a
// variable-latency memory (slave).
interface mc_datapath_hs_if #(
    parameter int XLEN = 32
);
    logic            MemReq;
    logic            MemWr;
    logic [XLEN-1:0] MemAddress;
    logic [XLEN-1:0] MemWriteData;
    logic [XLEN-1:0] MemReadData;
    logic            MemAck;

    modport master (
        output MemReq, MemWr, MemAddress, MemWriteData,
        input  MemReadData, MemAck
    );

    modport slave (
        input  MemReq, MemWr, MemAddress, MemWriteData,
        output MemReadData, MemAck
    );
endinterface

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle datapath with a req/ack memory sequencer (IDLE/REQ/DONE).
// Optional access timeout enabled by defining MC_DP_MEM_TIMEOUT_EN.
module mc_datapath_hs #(
    parameter int          XLEN        = 32,
    parameter int          NREGS       = 16,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  PCWrite,
    input  logic                  RegWrite,
    input  logic                  IorD,
    input  logic                  RegSel,
    input  logic                  RegDst,
    input  logic                  PCSrc,
    input  logic                  ALUSrcA,
    input  logic [3:0]            FlagWrite,
    input  logic [1:0]            MemToReg,
    input  logic [1:0]            ALUSrcB,
    input  logic [2:0]            ALUOperation,
    input  logic                  MemStart,
    input  logic                  MemWe,
    input  logic                  MemIRWrite,
    mc_datapath_hs_if.master      mem,
    output logic                  MemDone,
    output logic                  MemErr,
    output logic                  Z,
    output logic                  N,
    output logic                  V,
    output logic                  C,
    output logic [11:0]           CInstruction
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    mem_state_t      state_r;
    logic [XLEN-1:0] pc_r, mdr_r, a_r, b_r, alu_r;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] rf_r [NREGS];
    logic            z_r, n_r, v_r, c_r;
    logic            mem_req_r, mem_wr_r, irw_r, done_r, err_r;
    logic [XLEN-1:0] addr_r, wdata_r;

    logic [RW-1:0]   ra1_s, ra2_s, wa_s;
    logic [XLEN-1:0] wd_s, alu_a_s, alu_b_s, add_b_s, res_s;
    logic [XLEN:0]   sum_s;
    logic            add_cin_s, is_arith_s, carry_s, ovf_s;

    // Register-file address and write-data selection
    always_comb begin
        ra1_s = ir_r[16 +: RW];
        wd_s  = {XLEN{1'b0}};
        if (RegSel) begin
            ra2_s = ir_r[12 +: RW];
        end else begin
            ra2_s = ir_r[0 +: RW];
        end
        if (RegDst) begin
            wa_s = RW'(NREGS - 1);
        end else begin
            wa_s = ir_r[12 +: RW];
        end
        case (MemToReg)
            2'd0:    wd_s = mdr_r;
            2'd1:    wd_s = pc_r;
            2'd2:    wd_s = alu_r;
            default: wd_s = {XLEN{1'b0}};
        endcase
    end

    // ALU operand muxes; SUB feeds ~B with carry-in 1 so C means "no borrow"
    always_comb begin
        alu_b_s   = {XLEN{1'b0}};
        add_b_s   = {XLEN{1'b0}};
        add_cin_s = 1'b0;
        if (ALUSrcA) begin
            alu_a_s = a_r;
        end else begin
            alu_a_s = pc_r;
        end
        case (ALUSrcB)
            2'd0:    alu_b_s = b_r;
            2'd1:    alu_b_s = {{(XLEN-26){ir_r[25]}}, ir_r[25:0]};
            2'd2:    alu_b_s = {{(XLEN-12){ir_r[11]}}, ir_r[11:0]};
            default: alu_b_s = {{(XLEN-1){1'b0}}, 1'b1};
        endcase
        if (ALUOperation == 3'd1) begin
            add_b_s   = ~alu_b_s;
            add_cin_s = 1'b1;
        end else if (ALUOperation == 3'd7) begin
            add_b_s   = alu_b_s;
            add_cin_s = c_r;
        end else begin
            add_b_s   = alu_b_s;
            add_cin_s = 1'b0;
        end
    end

    assign sum_s = {1'b0, alu_a_s} + {1'b0, add_b_s} + {{XLEN{1'b0}}, add_cin_s};

    // ALU result select and arithmetic flag generation
    always_comb begin
        res_s      = {XLEN{1'b0}};
        is_arith_s = 1'b0;
        case (ALUOperation)
            3'd0, 3'd1, 3'd7: begin
                res_s      = sum_s[XLEN-1:0];
                is_arith_s = 1'b1;
            end
            3'd2:    res_s = alu_a_s & alu_b_s;
            3'd3:    res_s = alu_a_s | alu_b_s;
            3'd4:    res_s = alu_a_s ^ alu_b_s;
            3'd5:    res_s = ~alu_b_s;
            3'd6:    res_s = alu_b_s;
            default: res_s = {XLEN{1'b0}};
        endcase
        if (is_arith_s) begin
            carry_s = sum_s[XLEN];
            ovf_s   = (alu_a_s[XLEN-1] == add_b_s[XLEN-1]) && (res_s[XLEN-1] != alu_a_s[XLEN-1]);
        end else begin
            carry_s = 1'b0;
            ovf_s   = 1'b0;
        end
    end

    // Datapath state: PC, A/B, ALU-out, register file and flags
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_r  <= RESET_PC;
            a_r   <= {XLEN{1'b0}};
            b_r   <= {XLEN{1'b0}};
            alu_r <= {XLEN{1'b0}};
            z_r   <= 1'b0;
            n_r   <= 1'b0;
            v_r   <= 1'b0;
            c_r   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            a_r   <= rf_r[ra1_s];
            b_r   <= rf_r[ra2_s];
            alu_r <= res_s;
            if (PCWrite) begin
                pc_r <= PCSrc ? alu_r : res_s;
            end
            if (RegWrite) begin
                rf_r[wa_s] <= wd_s;
            end
            if (FlagWrite[3]) z_r <= (res_s == {XLEN{1'b0}});
            if (FlagWrite[2]) n_r <= res_s[XLEN-1];
            if (FlagWrite[1]) v_r <= ovf_s;
            if (FlagWrite[0]) c_r <= carry_s;
        end
    end

`ifdef MC_DP_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt_r;
`endif

    // Memory sequencer; address, write data and direction are frozen while REQ is held
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            mem_wr_r  <= 1'b0;
            irw_r     <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            addr_r    <= {XLEN{1'b0}};
            wdata_r   <= {XLEN{1'b0}};
            mdr_r     <= {XLEN{1'b0}};
            ir_r      <= 32'd0;
`ifdef MC_DP_MEM_TIMEOUT_EN
            cnt_r     <= {CW{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (MemStart) begin
                        addr_r    <= IorD ? alu_r : pc_r;
                        wdata_r   <= b_r;
                        mem_wr_r  <= MemWe;
                        irw_r     <= MemIRWrite;
                        mem_req_r <= 1'b1;
                        state_r   <= ST_REQ;
`ifdef MC_DP_MEM_TIMEOUT_EN
                        cnt_r     <= {CW{1'b0}};
`endif
                    end
                end
                ST_REQ: begin
                    if (mem.MemAck) begin
                        if (!mem_wr_r) begin
                            mdr_r <= mem.MemReadData;
                            if (irw_r) begin
                                ir_r <= mem.MemReadData[31:0];
                            end
                        end
                        mem_req_r <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end
`ifdef MC_DP_MEM_TIMEOUT_EN
                    // Abort on the cycle whose missing ack would bring the count to MEM_TIMEOUT
                    else if (cnt_r == CW'(MEM_TIMEOUT - 1)) begin
                        mem_req_r <= 1'b0;
                        err_r     <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem.MemReq       = mem_req_r;
    assign mem.MemWr        = mem_wr_r;
    assign mem.MemAddress   = addr_r;
    assign mem.MemWriteData = wdata_r;
    assign MemDone          = done_r;
`ifdef MC_DP_MEM_TIMEOUT_EN
    assign MemErr           = err_r;
`else
    assign MemErr           = 1'b0;
`endif
    assign Z                = z_r;
    assign N                = n_r;
    assign V                = v_r;
    assign C                = c_r;
    assign CInstruction     = ir_r[31:20];
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed self-checking bench for mc_datapath_hs (XLEN=32, NREGS=8, MEM_TIMEOUT=4).
module tb_mc_datapath_hs;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        PCWrite = 1'b0, RegWrite = 1'b0, IorD = 1'b0, RegSel = 1'b0;
    logic        RegDst = 1'b0, PCSrc = 1'b0, ALUSrcA = 1'b0;
    logic [3:0]  FlagWrite = 4'd0;
    logic [1:0]  MemToReg = 2'd0, ALUSrcB = 2'd0;
    logic [2:0]  ALUOperation = 3'd0;
    logic        MemStart = 1'b0, MemWe = 1'b0, MemIRWrite = 1'b0;
    logic        MemDone, MemErr, Z, N, V, C;
    logic [11:0] CInstruction;

    int n_tests = 0;
    int n_fail  = 0;

    mc_datapath_hs_if #(.XLEN(32)) mem_if ();

    mc_datapath_hs #(.XLEN(32), .NREGS(8), .RESET_PC(32'd0), .MEM_TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .RegWrite(RegWrite), .IorD(IorD),
        .RegSel(RegSel), .RegDst(RegDst), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .FlagWrite(FlagWrite), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB),
        .ALUOperation(ALUOperation), .MemStart(MemStart), .MemWe(MemWe),
        .MemIRWrite(MemIRWrite), .mem(mem_if), .MemDone(MemDone), .MemErr(MemErr),
        .Z(Z), .N(N), .V(V), .C(C), .CInstruction(CInstruction)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // One complete access: start, `waits` cycles without ack, then ack with rdata
    task automatic mem_op(input logic we, input logic irw, input logic iord,
                          input logic [31:0] rdata, input int waits,
                          output logic [31:0] addr, output logic [31:0] wdata);
        MemStart = 1'b1; MemWe = we; MemIRWrite = irw; IorD = iord;
        tick;
        MemStart = 1'b0; MemWe = 1'b0; MemIRWrite = 1'b0; IorD = 1'b0;
        check("req_up", 64'(mem_if.MemReq), 64'(1'b1));
        check("wr_latched", 64'(mem_if.MemWr), 64'(we));
        addr  = mem_if.MemAddress;
        wdata = mem_if.MemWriteData;
        for (int i = 0; i < waits; i++) begin
            tick;
            check("req_hold", 64'(mem_if.MemReq), 64'(1'b1));
            check("done_early", 64'(MemDone), 64'(1'b0));
        end
        mem_if.MemAck = 1'b1; mem_if.MemReadData = rdata;
        tick;
        mem_if.MemAck = 1'b0;
        check("done", 64'(MemDone), 64'(1'b1));
        check("req_down", 64'(mem_if.MemReq), 64'(1'b0));
        tick;
        check("done_pulse", 64'(MemDone), 64'(1'b0));
    endtask

    task automatic load_ir(input logic [31:0] ins);
        logic [31:0] a, w;
        mem_op(1'b0, 1'b1, 1'b0, ins, 0, a, w);
    endtask

    // Write val into register idx via IR rd field and MDR
    task automatic load_reg(input logic [3:0] idx, input logic [31:0] val);
        logic [31:0] a, w;
        load_ir({16'd0, idx, 12'd0});
        mem_op(1'b0, 1'b0, 1'b0, val, 1, a, w);
        MemToReg = 2'd0; RegDst = 1'b0; RegWrite = 1'b1;
        tick;
        RegWrite = 1'b0;
    endtask

    // Run an ALU op on A=r1, B=r2, then expose ALUreg/B via a write access
    task automatic run_alu(input logic [2:0] op, input logic [3:0] fw,
                           output logic [31:0] aluout, output logic [31:0] bval);
        ALUOperation = op; ALUSrcA = 1'b1; ALUSrcB = 2'd0;
        tick;
        tick;
        FlagWrite = fw;
        tick;
        FlagWrite = 4'd0;
        mem_op(1'b1, 1'b0, 1'b1, 32'h0, 0, aluout, bval);
    endtask

    initial begin
        logic [31:0] a, w;
        mem_if.MemAck = 1'b0;
        mem_if.MemReadData = 32'd0;
        tick;
        tick;
        Rst = 1'b0;
        check("rst_req", 64'(mem_if.MemReq), 64'(1'b0));
        check("rst_done", 64'(MemDone), 64'(1'b0));
        check("rst_err", 64'(MemErr), 64'(1'b0));
        check("rst_addr", 64'(mem_if.MemAddress), 64'h0);
        check("rst_wdata", 64'(mem_if.MemWriteData), 64'h0);
        check("rst_flags", 64'({Z, N, V, C}), 64'h0);
        check("rst_cins", 64'(CInstruction), 64'h0);

        // Fetch with 3 wait cycles
        mem_op(1'b0, 1'b1, 1'b0, 32'hE3A01005, 3, a, w);
        check("fetch_addr", 64'(a), 64'h0);
        check("fetch_cins", 64'(CInstruction), 64'hE3A);

        // ADD overflow
        load_reg(4'd1, 32'h7FFFFFFF);
        load_reg(4'd2, 32'h00000001);
        load_ir(32'h00013002);
        run_alu(3'd0, 4'b1111, a, w);
        check("add_res", 64'(a), 64'h80000000);
        check("add_b", 64'(w), 64'h1);
        check("add_flags", 64'({Z, N, V, C}), 64'b0110);

        // SUB 5-5
        load_reg(4'd1, 32'd5);
        load_reg(4'd2, 32'd5);
        load_ir(32'h00013002);
        run_alu(3'd1, 4'b1111, a, w);
        check("sub_res", 64'(a), 64'h0);
        check("sub_flags", 64'({Z, N, V, C}), 64'b1001);

        // ADC 2+3 with C=1, flags untouched
        load_reg(4'd1, 32'd2);
        load_reg(4'd2, 32'd3);
        load_ir(32'h00013002);
        run_alu(3'd7, 4'b0000, a, w);
        check("adc_res", 64'(a), 64'h6);
        check("adc_flags_kept", 64'({Z, N, V, C}), 64'b1001);

        run_alu(3'd4, 4'b1111, a, w);
        check("xor_res", 64'(a), 64'h1);
        check("xor_flags", 64'({Z, N, V, C}), 64'b0000);

        run_alu(3'd5, 4'b1111, a, w);
        check("mvn_res", 64'(a), 64'hFFFFFFFC);
        check("mvn_flags", 64'({Z, N, V, C}), 64'b0100);

        // PC <= 0x40 via MOV sext(ins[11:0]), then link write into r7
        load_ir(32'h00000040);
        ALUOperation = 3'd6; ALUSrcB = 2'd2; FlagWrite = 4'd0;
        tick;
        PCWrite = 1'b1; PCSrc = 1'b0;
        tick;
        PCWrite = 1'b0;
        RegDst = 1'b1; MemToReg = 2'd1; RegWrite = 1'b1;
        tick;
        RegWrite = 1'b0; RegDst = 1'b0; MemToReg = 2'd0;
        mem_op(1'b0, 1'b1, 1'b0, 32'h00000007, 0, a, w);
        check("pc_addr", 64'(a), 64'h40);
        tick;
        tick;
        mem_op(1'b1, 1'b0, 1'b0, 32'h0, 2, a, w);
        check("link_r7", 64'(w), 64'h40);

        // PCWrite together with a PC-addressed start: old PC latched
        ALUOperation = 3'd6; ALUSrcB = 2'd2;
        PCWrite = 1'b1; PCSrc = 1'b0;
        mem_op(1'b0, 1'b0, 1'b0, 32'h0, 0, a, w);
        PCWrite = 1'b0;
        check("pcw_old_addr", 64'(a), 64'h40);
        mem_op(1'b0, 1'b0, 1'b0, 32'h12345678, 0, a, w);
        check("pcw_new_addr", 64'(a), 64'h7);

        // Reset during REQ with a coincident ack
        MemStart = 1'b1; MemIRWrite = 1'b1;
        tick;
        MemStart = 1'b0; MemIRWrite = 1'b0;
        check("rreq_up", 64'(mem_if.MemReq), 64'(1'b1));
        mem_if.MemAck = 1'b1; mem_if.MemReadData = 32'hDEADBEEF; Rst = 1'b1;
        tick;
        Rst = 1'b0; mem_if.MemAck = 1'b0;
        check("rreq_drop", 64'(mem_if.MemReq), 64'(1'b0));
        check("rreq_nodone", 64'(MemDone), 64'(1'b0));
        check("rreq_cins", 64'(CInstruction), 64'h0);
        check("rreq_flags", 64'({Z, N, V, C}), 64'h0);
        tick;
        check("rreq_nodone2", 64'(MemDone), 64'(1'b0));
        ALUOperation = 3'd0; ALUSrcB = 2'd0;
        MemToReg = 2'd0; RegWrite = 1'b1;
        tick;
        RegWrite = 1'b0;
        tick;
        tick;
        mem_op(1'b1, 1'b0, 1'b0, 32'h0, 0, a, w);
        check("rreq_pc", 64'(a), 64'h0);
        check("rreq_mdr", 64'(w), 64'h0);

        load_ir(32'hABC00000);
        check("pre_to_cins", 64'(CInstruction), 64'hABC);
`ifdef MC_DP_MEM_TIMEOUT_EN
        begin
            logic seen;
            int   errs;
            seen = 1'b0;
            errs = 0;
            MemStart = 1'b1; MemIRWrite = 1'b1;
            tick;
            MemStart = 1'b0; MemIRWrite = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (MemErr) begin
                    errs++;
                    if (!seen) check("to_req_drop", 64'(mem_if.MemReq), 64'(1'b0));
                    seen = 1'b1;
                end
                check("to_nodone", 64'(MemDone), 64'(1'b0));
                tick;
            end
            check("to_err_seen", 64'(seen), 64'(1'b1));
            check("to_err_once", 64'(errs), 64'd1);
            check("to_cins_kept", 64'(CInstruction), 64'hABC);
        end
`else
        MemStart = 1'b1; MemIRWrite = 1'b1;
        tick;
        MemStart = 1'b0; MemIRWrite = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
        end
        check("noto_req", 64'(mem_if.MemReq), 64'(1'b1));
        check("noto_err", 64'(MemErr), 64'(1'b0));
        mem_if.MemAck = 1'b1; mem_if.MemReadData = 32'h11100000;
        tick;
        mem_if.MemAck = 1'b0;
        check("noto_done", 64'(MemDone), 64'(1'b1));
        tick;
        check("noto_cins", 64'(CInstruction), 64'h111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_datapath_hs.md
# mc_datapath_hs

Parametrised multicycle datapath with an internal memory-access handshake unit. It replaces the fixed-width, single-cycle-memory datapath, and sits between the multicycle controller and a variable-latency memory port. It holds PC, IR, MDR, A/B, ALU-out and flag registers plus an `NREGS` register file. Memory accesses run through a req/ack sequencer, so the controller waits on `MemDone` instead of assuming one-cycle memory.

## Interface
Parameters:
- `XLEN`, 32: datapath width; ≥ 32. The instruction is always `MemReadData[31:0]`.
- `NREGS`, 16: register count; power of two, 2..16. Register indices use the low `$clog2(NREGS)` bits of the 4-bit instruction fields.
- `RESET_PC`, 0: PC value after reset.
- `MEM_TIMEOUT`, 15: abort threshold in cycles. Used only with `MC_DP_MEM_TIMEOUT_EN`.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `PCWrite`, `RegWrite`, `IorD`, `RegSel`, `RegDst`, `PCSrc`, `ALUSrcA` in 1 each: controller selects and enables, with the same meaning as the previous-generation datapath.
- `FlagWrite` in 4: per-flag write enables, bit order {Z,N,V,C}.
- `MemToReg`, `ALUSrcB` in 2 each: write-data mux {MDR, PC, ALUout, 0} and ALU B-input mux {B, sext(ins[25:0]), sext(ins[11:0]), 1}.
- `ALUOperation` in 3: ALU opcode.
- `MemStart` in 1: request one memory access.
- `MemWe` in 1: access is a write; sampled with `MemStart`.
- `MemIRWrite` in 1: also load IR on read completion; sampled with `MemStart`.
- `MemReadData` in XLEN: memory read data.
- `MemAck` in 1: memory completes the access this cycle.
- `MemReq` out 1: access outstanding.
- `MemWr` out 1: latched `MemWe`.
- `MemAddress`, `MemWriteData` out XLEN: latched address and write data.
- `MemDone` out 1: one-cycle completion pulse.
- `MemErr` out 1: one-cycle timeout pulse.
- `Z`, `N`, `V`, `C` out 1 each: flag registers.
- `CInstruction` out 12: `IR[31:20]`.

## Operation
- **Register file:**
  - Reads are combinational: port 1 reads `ins[19:16]`; port 2 reads `ins[3:0]`, or `ins[15:12]` when `RegSel` = 1.
  - Write destination is `ins[15:12]`, or `NREGS-1` when `RegDst` = 1.
  - A and B capture the read ports every cycle.
- **ALU ops:** 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 MVN (~B), 6 MOV (B), 7 ADC (A+B+C).
- **Flag generation:**
  - Z means result == 0; N is the result MSB.
  - ADD/ADC/SUB: C is the carry out of the XLEN-bit add, with SUB computed as A+~B+1 (C=1 means no borrow). V is signed overflow.
  - Logic ops: C = V = 0.
  - A flag updates only when its `FlagWrite` bit is 1.
- **ALU-out register:** ALUreg captures the ALU result every cycle. PC loads `PCSrc` ? ALUreg : ALU when `PCWrite` = 1.
- **Memory sequencer states:** IDLE, REQ, DONE.
- **IDLE:**
  - `MemStart` latches the address (`IorD` ? ALUreg : PC), B as write data, `MemWe` and `MemIRWrite`.
  - Next state is REQ.
- **REQ:**
  - `MemReq` = 1 and address/data stay stable.
  - On `MemAck` = 1: a read loads MDR from `MemReadData`, and loads IR (from `MemReadData[31:0]`) if `MemIRWrite` was latched. A write loads nothing. Next state is DONE.
- **DONE:** `MemDone` = 1 for one cycle, then back to IDLE.
- **Ignored inputs:**
  - `MemStart` outside IDLE.
  - `MemAck` outside REQ.

## Timing
- **Reset values:**
  - PC = `RESET_PC`.
  - IR, MDR, A, B, ALUreg, all registers and all flags = 0.
  - `MemReq` = `MemWr` = `MemDone` = `MemErr` = 0; `MemAddress` = `MemWriteData` = 0; state IDLE.
- **Minimum access:** `MemStart` in cycle t, `MemReq` high in t+1, `MemAck` in t+1, MDR/IR valid and `MemDone` high in t+2.
- **Each extra wait cycle** before `MemAck` adds one cycle.
- **Reset mid-access:** `MemReq` drops at the next edge; no MDR/IR update and no `MemDone`.
- **Register write** is visible on the read ports the cycle after the write edge; there is no write-through bypass.
- **Simultaneous `PCWrite` and a PC-addressed `MemStart`:** the old PC is latched as the address.

## Configuration
- **`MC_DP_MEM_TIMEOUT_EN` defined:**
  - A counter clears on entry to REQ and increments each REQ cycle without `MemAck`.
  - When it reaches `MEM_TIMEOUT`, the unit pulses `MemErr` for one cycle instead of `MemDone`, drops `MemReq`, returns to IDLE, and leaves MDR/IR unchanged.
  - `MemAck` in the same cycle the count is reached wins (normal completion).
- **`MC_DP_MEM_TIMEOUT_EN` undefined:** no counter; `MemErr` is tied to 0 and REQ waits indefinitely.

## Test plan
- **Reset and fetch:** reset, then `MemStart` with `IorD` = 0 and `MemIRWrite` = 1, ack after 3 wait cycles with 0xE3A01005 → `MemAddress` = 0, `MemDone` 5 cycles after start, IR = 0xE3A01005, `CInstruction` = 0xE3A.
- **ADD overflow:** A = 0x7FFFFFFF, B = 1, ADD, `FlagWrite` = 4'b1111 → ALUreg = 0x80000000, N = 1, V = 1, C = 0, Z = 0.
- **SUB then ADC:** SUB 5−5 gives Z = 1 and C = 1. A following ADC of 2+3 gives 6.
- **Link write:** `RegDst` = 1, `MemToReg` = 1, PC = 0x40 with `NREGS` = 8 → r7 = 0x40.
- **Reset during REQ:** `Rst` asserted while `MemReq` = 1 → `MemReq` = 0 next cycle, no `MemDone`, MDR = 0.
- **Timeout:** with `MC_DP_MEM_TIMEOUT_EN` and `MEM_TIMEOUT` = 4, no ack → `MemErr` pulses once, `MemReq` drops, IR unchanged.
